// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the MIPS execute stage.
// Start/busy/done handshake, one quotient bit per cycle, cancellable on flush.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             sign_op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;        // dividend shifts out MSB-first, quotient bits shift in at LSB
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_dbz_pend;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_b_zero;

    assign w_mag_a  = (sign_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_mag_b  = (sign_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign w_b_zero = (b == '0);
    assign w_shift  = {r_rem, r_q[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_dbz_pend  <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        // On divide-by-zero r_q keeps the raw dividend for the HI result
                        r_q        <= w_b_zero ? a : w_mag_a;
                        r_div      <= w_mag_b;
                        r_rem      <= '0;
                        r_qneg     <= sign_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_rneg     <= sign_op & a[WIDTH-1];
                        r_dbz_pend <= w_b_zero;
                        r_cnt      <= '0;
                        r_state    <= w_b_zero ? S_FIN : S_CALC;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (!w_trial[WIDTH]) begin
                            r_rem <= w_trial[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(WIDTH - 1))
                            r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (!cancel) begin
                        if (r_dbz_pend) begin
                            r_quotient  <= '1;
                            r_remainder <= r_q;
                        end else begin
                            r_quotient  <= r_qneg ? (~r_q + 1'b1) : r_q;
                            r_remainder <= r_rneg ? (~r_rem + 1'b1) : r_rem;
                        end
                        r_dbz  <= r_dbz_pend;
                        r_done <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        sign_op = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    // Last results the DUT should be holding
    logic [31:0] exp_q = '0;
    logic [31:0] exp_r = '0;
    logic        exp_dbz = 1'b0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .sign_op(sign_op),
        .cancel(cancel), .a(a), .b(b), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit signed arithmetic truncates toward zero, so -2^31/-1 needs no care
    task automatic model(input logic s, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sx, sy;
        if (y == 0) begin
            q = 32'hFFFF_FFFF; r = x; z = 1'b1;
        end else begin
            if (s) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
            end else begin
                sx = longint'({32'd0, x});
                sy = longint'({32'd0, y});
            end
            q = 32'(sx / sy);
            r = 32'(sx % sy);
            z = 1'b0;
        end
    endtask

    // Caller is #1 past an edge; the next posedge is E0
    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
        sign_op = s; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcy);
        lat = 0; bcy = 0;
        while (!done && lat < 200) begin
            if (busy) bcy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Leaves the bench in the done cycle so a back-to-back start can follow
    task automatic run_op(input logic s, input logic [31:0] x, input logic [31:0] y);
        int lat, bcy, exp_lat;
        logic [31:0] mq, mr;
        logic mz;
        model(s, x, y, mq, mr, mz);
        exp_lat = mz ? 1 : 33;
        issue(s, x, y);
        wait_done(lat, bcy);
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(bcy), 32'(exp_lat));
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("quotient", quotient, mq);
        check("remainder", remainder, mr);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, mz});
        exp_q = mq; exp_r = mr; exp_dbz = mz;
        $display("div s=%0d a=%h b=%h -> q=%h r=%h dbz=%0d lat=%0d",
                 s, x, y, quotient, remainder, div_by_zero, lat);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_q"}, quotient, exp_q);
        check({tag, "_r"}, remainder, exp_r);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check_held("rst");
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(1'b0, 32'd100, 32'd7);
        @(posedge clk); #1;
        check("done_width", {31'd0, done}, 32'd0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b0, 32'h1234_5678, 32'd0);
        run_op(1'b1, 32'h8765_4321, 32'd0);
        run_op(1'b0, 32'd100, 32'd7);

        // Back-to-back: second start issued in the done cycle
        run_op(1'b0, 32'd50, 32'd5);
        @(posedge clk); #1;

        // Cancel mid-CALC: results must hold the 50/5 values
        issue(1'b0, 32'd100, 32'd7);
        repeat (8) begin @(posedge clk); #1; end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_busy", {31'd0, busy}, 32'd0);
        watch_no_done("cancel_no_done", 40);
        check_held("cancel");

        // Start together with cancel in IDLE is dropped
        start = 1'b1; cancel = 1'b1; a = 32'd9; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("idle_cancel_busy", {31'd0, busy}, 32'd0);
        watch_no_done("idle_cancel_no_done", 40);
        check_held("idle_cancel");

        // Reset mid-CALC clears outputs at once and loses the operation
        issue(1'b1, 32'd1000, 32'd3);
        repeat (5) begin @(posedge clk); #1; end
        #2 resetn = 1'b0;
        #1;
        exp_q = '0; exp_r = '0; exp_dbz = 1'b0;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check_held("rstmid");
        @(negedge clk); resetn = 1'b1;
        watch_no_done("rstmid_no_done", 40);

        // Random operands, biased toward signs, small divisors and zero
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            logic rs;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 20);
                2: rb = -($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            run_op(rs, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
